// File: rtl/control_sequencer.sv
// Microcode sequencer for the 8-bit CPU: steps fetch/execute micro-steps T0..T4 and
// decodes the opcode and ALU flags into register load/output strobes.
module control_sequencer #(
   parameter int OPCODE_W  = 4,
   parameter bit EARLY_END = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                flag_c,
   input  logic                flag_z,
   output logic [2:0]          step,
   output logic                pc_out,
   output logic                pc_inc,
   output logic                pc_load,
   output logic                mar_load,
   output logic                ram_out,
   output logic                ram_load,
   output logic                ir_load,
   output logic                ir_out,
   output logic                a_load,
   output logic                a_out,
   output logic                b_load,
   output logic                alu_out,
   output logic                alu_sub,
   output logic                flags_load,
   output logic                out_load,
   output logic                halted
);

   localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'h1);
   localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'h2);
   localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'h3);
   localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4'h4);
   localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(4'h5);
   localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(4'h6);
   localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(4'h7);
   localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(4'h8);
   localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'hE);
   localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'hF);

   logic [2:0] step_reg, step_next;
   logic       halted_reg, halted_next;
   logic [2:0] last_step;
   logic       active;

   assign step   = step_reg;
   assign halted = halted_reg;
   // Strobes are suppressed during reset, while paused, and once halted.
   assign active = rst_n & en & ~halted_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_reg   <= 3'd0;
         halted_reg <= 1'b0;
      end else begin
         step_reg   <= step_next;
         halted_reg <= halted_next;
      end
   end

   always_comb begin
      last_step = 3'd1;
      case (opcode)
         OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: last_step = 3'd2;
         OP_LDA, OP_STA:                               last_step = 3'd3;
         OP_ADD, OP_SUB:                               last_step = 3'd4;
         default:                                      last_step = 3'd1;
      endcase
   end

   always_comb begin
      step_next   = step_reg;
      halted_next = halted_reg;
      if (en && !halted_reg) begin
         if (step_reg == 3'd2 && opcode == OP_HLT) begin
            // Freeze at T2 until the next reset.
            halted_next = 1'b1;
         end else if (EARLY_END) begin
            step_next = (step_reg >= last_step) ? 3'd0 : step_reg + 3'd1;
         end else begin
            step_next = (step_reg >= 3'd4) ? 3'd0 : step_reg + 3'd1;
         end
      end
   end

   always_comb begin
      pc_out     = 1'b0;
      pc_inc     = 1'b0;
      pc_load    = 1'b0;
      mar_load   = 1'b0;
      ram_out    = 1'b0;
      ram_load   = 1'b0;
      ir_load    = 1'b0;
      ir_out     = 1'b0;
      a_load     = 1'b0;
      a_out      = 1'b0;
      b_load     = 1'b0;
      alu_out    = 1'b0;
      alu_sub    = 1'b0;
      flags_load = 1'b0;
      out_load   = 1'b0;
      if (active) begin
         case (step_reg)
            3'd0: begin
               pc_out   = 1'b1;
               mar_load = 1'b1;
            end
            3'd1: begin
               ram_out = 1'b1;
               ir_load = 1'b1;
               pc_inc  = 1'b1;
            end
            3'd2: begin
               case (opcode)
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                     ir_out   = 1'b1;
                     mar_load = 1'b1;
                  end
                  OP_LDI: begin
                     ir_out = 1'b1;
                     a_load = 1'b1;
                  end
                  OP_JMP: begin
                     ir_out  = 1'b1;
                     pc_load = 1'b1;
                  end
                  OP_JC: begin
                     ir_out  = flag_c;
                     pc_load = flag_c;
                  end
                  OP_JZ: begin
                     ir_out  = flag_z;
                     pc_load = flag_z;
                  end
                  OP_OUT: begin
                     a_out    = 1'b1;
                     out_load = 1'b1;
                  end
                  default: ;
               endcase
            end
            3'd3: begin
               case (opcode)
                  OP_LDA: begin
                     ram_out = 1'b1;
                     a_load  = 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     ram_out = 1'b1;
                     b_load  = 1'b1;
                  end
                  OP_STA: begin
                     a_out    = 1'b1;
                     ram_load = 1'b1;
                  end
                  default: ;
               endcase
            end
            3'd4: begin
               if (opcode == OP_ADD || opcode == OP_SUB) begin
                  alu_out    = 1'b1;
                  a_load     = 1'b1;
                  flags_load = 1'b1;
                  alu_sub    = (opcode == OP_SUB);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: one EARLY_END=1 instance for most scenarios and
// one EARLY_END=0 instance compared alongside it for the fixed-length run.
module tb_control_sequencer;

   localparam logic [14:0] PCO  = 15'h4000;
   localparam logic [14:0] PCI  = 15'h2000;
   localparam logic [14:0] PCL  = 15'h1000;
   localparam logic [14:0] MARL = 15'h0800;
   localparam logic [14:0] RAMO = 15'h0400;
   localparam logic [14:0] RAML = 15'h0200;
   localparam logic [14:0] IRL  = 15'h0100;
   localparam logic [14:0] IRO  = 15'h0080;
   localparam logic [14:0] AL   = 15'h0040;
   localparam logic [14:0] AO   = 15'h0020;
   localparam logic [14:0] BL   = 15'h0010;
   localparam logic [14:0] ALUO = 15'h0008;
   localparam logic [14:0] SUBF = 15'h0004;
   localparam logic [14:0] FL   = 15'h0002;
   localparam logic [14:0] OUTL = 15'h0001;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b1;
   logic [3:0] opcode = 4'h0;
   logic       flag_c = 1'b0;
   logic       flag_z = 1'b0;

   logic [2:0] step1, step0;
   logic       halted1, halted0;
   logic [14:0] ctrl1, ctrl0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   control_sequencer #(.OPCODE_W(4), .EARLY_END(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .en(en), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
      .step(step1),
      .pc_out(ctrl1[14]), .pc_inc(ctrl1[13]), .pc_load(ctrl1[12]), .mar_load(ctrl1[11]),
      .ram_out(ctrl1[10]), .ram_load(ctrl1[9]), .ir_load(ctrl1[8]), .ir_out(ctrl1[7]),
      .a_load(ctrl1[6]), .a_out(ctrl1[5]), .b_load(ctrl1[4]), .alu_out(ctrl1[3]),
      .alu_sub(ctrl1[2]), .flags_load(ctrl1[1]), .out_load(ctrl1[0]),
      .halted(halted1)
   );

   control_sequencer #(.OPCODE_W(4), .EARLY_END(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .en(en), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
      .step(step0),
      .pc_out(ctrl0[14]), .pc_inc(ctrl0[13]), .pc_load(ctrl0[12]), .mar_load(ctrl0[11]),
      .ram_out(ctrl0[10]), .ram_load(ctrl0[9]), .ir_load(ctrl0[8]), .ir_out(ctrl0[7]),
      .a_load(ctrl0[6]), .a_out(ctrl0[5]), .b_load(ctrl0[4]), .alu_out(ctrl0[3]),
      .alu_sub(ctrl0[2]), .flags_load(ctrl0[1]), .out_load(ctrl0[0]),
      .halted(halted0)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      en = 1'b1;
      opcode = 4'h2;
      rst_n = 1'b0;
      tick();
      checks++;
      if (ctrl1 !== 15'h0) begin
         errors++;
         $display("FAIL reset_ctrl_zero got=%h exp=%h", ctrl1, 15'h0);
      end
      tick();
      rst_n = 1'b1;
      #1;
      checks++;
      if (step1 !== 3'd0 || halted1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_state step=%0d halted=%0b exp step=0 halted=0", step1, halted1);
      end
      checks++;
      if (ctrl1 !== (PCO | MARL)) begin
         errors++;
         $display("FAIL reset_first_ctrl got=%h exp=%h", ctrl1, PCO | MARL);
      end
      $display("test_reset done: step=%0d ctrl=%h", step1, ctrl1);
   endtask

   task automatic test_arith(input logic [3:0] op, input logic sub);
      logic [14:0] exp_ctrl [5];
      exp_ctrl[0] = PCO | MARL;
      exp_ctrl[1] = RAMO | IRL | PCI;
      exp_ctrl[2] = IRO | MARL;
      exp_ctrl[3] = RAMO | BL;
      exp_ctrl[4] = ALUO | AL | FL | (sub ? SUBF : 15'h0);
      opcode = op;
      #1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (step1 !== 3'(i) || ctrl1 !== exp_ctrl[i]) begin
            errors++;
            $display("FAIL arith_op%h_T%0d step=%0d ctrl=%h exp step=%0d ctrl=%h",
                     op, i, step1, ctrl1, i, exp_ctrl[i]);
         end
         tick();
      end
      checks++;
      if (step1 !== 3'd0) begin
         errors++;
         $display("FAIL arith_op%h_wrap step=%0d exp=0", op, step1);
      end
      $display("test_arith op=%h done: step=%0d", op, step1);
   endtask

   task automatic test_cond_jump(input logic [3:0] op, input logic fc, input logic fz,
                                 input logic taken);
      opcode = op;
      flag_c = fc;
      flag_z = fz;
      tick();
      tick();
      checks++;
      if (step1 !== 3'd2 || ctrl1 !== (taken ? (IRO | PCL) : 15'h0)) begin
         errors++;
         $display("FAIL jump_op%h_taken%0b step=%0d ctrl=%h exp step=2 ctrl=%h",
                  op, taken, step1, ctrl1, taken ? (IRO | PCL) : 15'h0);
      end
      tick();
      checks++;
      if (step1 !== 3'd0) begin
         errors++;
         $display("FAIL jump_op%h_end step=%0d exp=0", op, step1);
      end
      $display("test_cond_jump op=%h c=%0b z=%0b ctrl_t2_expected=%0b", op, fc, fz, taken);
   endtask

   task automatic test_lda_pause();
      opcode = 4'h1;
      tick();
      tick();
      tick();
      checks++;
      if (step1 !== 3'd3 || ctrl1 !== (RAMO | AL)) begin
         errors++;
         $display("FAIL lda_t3 step=%0d ctrl=%h exp step=3 ctrl=%h", step1, ctrl1, RAMO | AL);
      end
      en = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (step1 !== 3'd3 || ctrl1 !== 15'h0) begin
            errors++;
            $display("FAIL lda_paused%0d step=%0d ctrl=%h exp step=3 ctrl=0", i, step1, ctrl1);
         end
      end
      en = 1'b1;
      #1;
      checks++;
      if (ctrl1 !== (RAMO | AL)) begin
         errors++;
         $display("FAIL lda_resume ctrl=%h exp=%h", ctrl1, RAMO | AL);
      end
      tick();
      checks++;
      if (step1 !== 3'd0) begin
         errors++;
         $display("FAIL lda_end step=%0d exp=0", step1);
      end
      $display("test_lda_pause done: step=%0d", step1);
   endtask

   task automatic test_short_ops();
      logic [3:0]  ops  [3];
      int          last [3];
      logic [14:0] ctl  [3];
      ops[0] = 4'h5; last[0] = 2; ctl[0] = IRO | AL;
      ops[1] = 4'hE; last[1] = 2; ctl[1] = AO | OUTL;
      ops[2] = 4'h4; last[2] = 3; ctl[2] = AO | RAML;
      for (int k = 0; k < 3; k++) begin
         opcode = ops[k];
         for (int s = 0; s < last[k]; s++) tick();
         checks++;
         if (ctrl1 !== ctl[k]) begin
            errors++;
            $display("FAIL short_op%h_ctrl got=%h exp=%h", ops[k], ctrl1, ctl[k]);
         end
         tick();
         checks++;
         if (step1 !== 3'd0) begin
            errors++;
            $display("FAIL short_op%h_end step=%0d exp=0", ops[k], step1);
         end
         $display("test_short_ops op=%h ctrl=%h", ops[k], ctl[k]);
      end
   endtask

   task automatic test_halt();
      opcode = 4'hF;
      tick();
      tick();
      checks++;
      if (step1 !== 3'd2 || ctrl1 !== 15'h0 || halted1 !== 1'b0) begin
         errors++;
         $display("FAIL hlt_t2 step=%0d ctrl=%h halted=%0b exp step=2 ctrl=0 halted=0",
                  step1, ctrl1, halted1);
      end
      tick();
      checks++;
      if (halted1 !== 1'b1 || step1 !== 3'd2) begin
         errors++;
         $display("FAIL hlt_set halted=%0b step=%0d exp halted=1 step=2", halted1, step1);
      end
      for (int i = 0; i < 10; i++) begin
         en = ~en;
         tick();
         checks++;
         if (halted1 !== 1'b1 || step1 !== 3'd2 || ctrl1 !== 15'h0) begin
            errors++;
            $display("FAIL hlt_hold%0d halted=%0b step=%0d ctrl=%h exp 1/2/0",
                     i, halted1, step1, ctrl1);
         end
      end
      en = 1'b1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (halted1 !== 1'b0 || step1 !== 3'd0) begin
         errors++;
         $display("FAIL hlt_reset halted=%0b step=%0d exp 0/0", halted1, step1);
      end
      tick();
      rst_n = 1'b1;
      #1;
      $display("test_halt done: halted=%0b step=%0d", halted1, step1);
   endtask

   task automatic test_undefined();
      logic [14:0] fetch [2];
      int exp1, exp0;
      logic [14:0] c1, c0;
      fetch[0] = PCO | MARL;
      fetch[1] = RAMO | IRL | PCI;
      opcode = 4'hB;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         exp1 = i % 2;
         exp0 = i % 5;
         c1 = fetch[exp1];
         c0 = (exp0 < 2) ? fetch[exp0] : 15'h0;
         checks++;
         if (step1 !== 3'(exp1) || ctrl1 !== c1) begin
            errors++;
            $display("FAIL undef_early_c%0d step=%0d ctrl=%h exp step=%0d ctrl=%h",
                     i, step1, ctrl1, exp1, c1);
         end
         checks++;
         if (step0 !== 3'(exp0) || ctrl0 !== c0) begin
            errors++;
            $display("FAIL undef_full_c%0d step=%0d ctrl=%h exp step=%0d ctrl=%h",
                     i, step0, ctrl0, exp0, c0);
         end
         tick();
      end
      $display("test_undefined done: step1=%0d step0=%0d", step1, step0);
   endtask

   initial begin
      test_reset();
      test_arith(4'h2, 1'b0);
      test_arith(4'h3, 1'b1);
      test_cond_jump(4'h7, 1'b1, 1'b0, 1'b1);
      test_cond_jump(4'h7, 1'b0, 1'b1, 1'b0);
      test_cond_jump(4'h8, 1'b0, 1'b1, 1'b1);
      test_cond_jump(4'h8, 1'b1, 1'b0, 1'b0);
      test_lda_pause();
      test_short_ops();
      test_halt();
      test_undefined();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
